// File: rtl/dmem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_if
// Description : Requester-side command/response bundle for one dmem_arb port.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arb_if;
    logic        req;
    logic        we;
    logic        sign;
    logic [1:0]  mask_op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rd;

    modport master (
        output req, we, sign, mask_op, addr, data,
        input  gnt, rvalid, rd
    );

    modport slave (
        input  req, we, sign, mask_op, addr, data,
        output gnt, rvalid, rd
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb
// Description : Two-port arbiter and A/B/C access sequencer for the data memory.
//               Define DMEM_ARB_RR_EN for round-robin; default is fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb #(
    parameter bit RR_INIT = 1'b1
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    dmem_arb_if.slave        p0,
    dmem_arb_if.slave        p1,
    output logic             dram_we_o,
    output logic             sign_o,
    output logic [1:0]       mask_op_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      data_o,
    input  wire logic [31:0] rd_i
);

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic        w_resp;

    logic        r_last_q,    w_last_d;
    logic        r_b_valid_q, w_b_valid_d;
    logic        r_b_port_q,  w_b_port_d;
    logic        r_b_we_q,    w_b_we_d;
    logic        r_b_sign_q,  w_b_sign_d;
    logic [1:0]  r_b_mask_q,  w_b_mask_d;
    logic [31:0] r_b_addr_q,  w_b_addr_d;
    logic [31:0] r_b_data_q,  w_b_data_d;

    logic        r_rvalid0_q, w_rvalid0_d;
    logic        r_rvalid1_q, w_rvalid1_d;
    logic [31:0] r_rd0_q,     w_rd0_d;
    logic [31:0] r_rd1_q,     w_rd1_d;

    // Stage A: grants are blocked while reset is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst_i) begin
`ifdef DMEM_ARB_RR_EN
            if (p0.req && p1.req) begin
                w_gnt0 = r_last_q;
                w_gnt1 = ~r_last_q;
            end else begin
                w_gnt0 = p0.req;
                w_gnt1 = p1.req;
            end
`else
            w_gnt0 = p0.req;
            w_gnt1 = p1.req & ~p0.req;
`endif
        end
        w_any_gnt = w_gnt0 | w_gnt1;
    end

`ifndef DMEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = r_last_q;
`endif

    assign p0.gnt = w_gnt0;
    assign p1.gnt = w_gnt1;

    always_comb begin
        w_last_d    = r_last_q;
        w_b_port_d  = r_b_port_q;
        w_b_we_d    = r_b_we_q;
        w_b_sign_d  = r_b_sign_q;
        w_b_mask_d  = r_b_mask_q;
        w_b_addr_d  = r_b_addr_q;
        w_b_data_d  = r_b_data_q;
        w_b_valid_d = w_any_gnt;

        if (w_any_gnt) begin
            w_last_d   = w_gnt1;
            w_b_port_d = w_gnt1;
            if (w_gnt1) begin
                w_b_we_d   = p1.we;
                w_b_sign_d = p1.sign;
                w_b_mask_d = p1.mask_op;
                w_b_addr_d = p1.addr;
                w_b_data_d = p1.data;
            end else begin
                w_b_we_d   = p0.we;
                w_b_sign_d = p0.sign;
                w_b_mask_d = p0.mask_op;
                w_b_addr_d = p0.addr;
                w_b_data_d = p0.data;
            end
        end

        // Stage C: capture the asynchronous read of the access in stage B.
        w_resp      = r_b_valid_q & ~r_b_we_q;
        w_rvalid0_d = w_resp & ~r_b_port_q;
        w_rvalid1_d = w_resp &  r_b_port_q;
        w_rd0_d     = w_rvalid0_d ? rd_i : r_rd0_q;
        w_rd1_d     = w_rvalid1_d ? rd_i : r_rd1_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_q    <= RR_INIT;
            r_b_valid_q <= 1'b0;
            r_b_port_q  <= 1'b0;
            r_b_we_q    <= 1'b0;
            r_b_sign_q  <= 1'b0;
            r_b_mask_q  <= 2'b00;
            r_b_addr_q  <= 32'h0;
            r_b_data_q  <= 32'h0;
            r_rvalid0_q <= 1'b0;
            r_rvalid1_q <= 1'b0;
            r_rd0_q     <= 32'h0;
            r_rd1_q     <= 32'h0;
        end else begin
            r_last_q    <= w_last_d;
            r_b_valid_q <= w_b_valid_d;
            r_b_port_q  <= w_b_port_d;
            r_b_we_q    <= w_b_we_d;
            r_b_sign_q  <= w_b_sign_d;
            r_b_mask_q  <= w_b_mask_d;
            r_b_addr_q  <= w_b_addr_d;
            r_b_data_q  <= w_b_data_d;
            r_rvalid0_q <= w_rvalid0_d;
            r_rvalid1_q <= w_rvalid1_d;
            r_rd0_q     <= w_rd0_d;
            r_rd1_q     <= w_rd1_d;
        end
    end

    // Write strobe is gated by reset so an in-flight write dies in the reset cycle.
    assign dram_we_o = r_b_valid_q & r_b_we_q & ~rst_i;
    assign sign_o    = r_b_sign_q;
    assign mask_op_o = r_b_mask_q;
    assign addr_o    = r_b_addr_q;
    assign data_o    = r_b_data_q;

    assign p0.rvalid = r_rvalid0_q;
    assign p1.rvalid = r_rvalid1_q;
    assign p0.rd     = r_rd0_q;
    assign p1.rd     = r_rd1_q;

endmodule
`default_nettype wire

// File: doc/dmem_arb.md
# dmem_arb

Two-port arbiter and access sequencer in front of the data memory (`dmem`) in the single-cycle miniRV build. It lets the core load/store unit (port 0) and the debug/program-loader port (port 1) share the one data-memory port. Requests are granted through a req/gnt handshake, registered into a one-entry access stage, and read data is returned through a registered response stage. Sustained throughput is one access per cycle.

## Interface
Parameters:
- `RR_INIT`, default 1: reset value of the last-granted pointer. 1 means port 0 wins the first tie.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `pN_req_i`  in  1  port N (N = 0, 1) request; held with its command until `pN_gnt_o`
- `pN_we_i`  in  1  port N write (1) / read (0)
- `pN_sign_i`  in  1  port N sign-extend for sub-word reads
- `pN_mask_op_i`  in  2  port N access size: 00 byte, 01 half, 10 word
- `pN_addr_i`  in  32  port N byte address
- `pN_data_i`  in  32  port N write data
- `pN_gnt_o`  out  1  port N command accepted this cycle (combinational)
- `pN_rvalid_o`  out  1  port N read data valid, one-cycle pulse
- `pN_rd_o`  out  32  port N read data
- `dram_we_o`  out  1  to dmem `dram_we_i`
- `sign_o`  out  1  to dmem `sign_i`
- `mask_op_o`  out  2  to dmem `mask_op_i`
- `addr_o`  out  32  to dmem `addr_i`
- `data_o`  out  32  to dmem `data_i`
- `rd_i`  in  32  from dmem `rd_o` (asynchronous read)

Clock and reset: one clock (`clk_i`). Reset (`rst_i`) is synchronous and active-high.

## Operation
- **Stage A, arbitration (combinational):**
  - With `rst_i` low, at most one `pN_gnt_o` is high per cycle, and only when `pN_req_i` is high.
  - Single requester: it is granted.
  - Both requesting: the port not equal to `last` is granted.
  - `last` updates to the granted port on every grant.
- **Stage B, access register:**
  - On a grant, the winner's {port id, we, sign, mask_op, addr, data} are latched and `b_valid` is set to 1.
  - With no grant, `b_valid` is cleared to 0.
- **Memory drive:**
  - `addr_o`, `data_o`, `sign_o` and `mask_op_o` come from the stage-B register.
  - `dram_we_o` = `b_valid & b_we & ~rst_i`.
  - The write commits at the end of the stage-B cycle.
- **Stage C, response:**
  - If stage B holds a read, `rd_i` is captured into the owning port's `pN_rd_o` and `pN_rvalid_o` pulses for one cycle.
  - Writes produce no `rvalid`.
- **Ordering:** accesses reach memory in grant order. A read granted the cycle after a write to the same address returns the new data.
- **Hold:** `pN_rd_o` keeps its last value until that port's next read response.

## Timing
- Grant at cycle N → memory access at N+1 → `rvalid`/`rd` at N+2.
- Back-to-back grants are allowed. Both ports requesting continuously alternate 0, 1, 0, 1, with no idle cycles.
- A requester must keep its `req`/command stable until `gnt`. Dropping `req` before `gnt` cancels the request.
- **Reset values:** all `gnt`, `rvalid` and `dram_we_o` are 0. `addr_o`, `data_o`, `pN_rd_o` and `mask_op_o` are 0; `sign_o` is 0; `b_valid` is 0; `last` = `RR_INIT`.
- **Reset mid-operation:** a stage-B write in the reset cycle is suppressed, because `dram_we_o` is forced low. Pending stage-B/C responses are discarded. Grants are blocked while `rst_i` is high.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration as described.
- `DMEM_ARB_RR_EN` undefined:
  - Fixed priority: port 0 always wins ties, and port 1 is granted only when `p0_req_i` is low.
  - `last` still exists but does not affect arbitration.

## Test plan
- **Reset:** hold `rst_i`=1 for 3 cycles with both reqs high → no gnt, `dram_we_o`=0, all outputs 0.
- **Single write then read:**
  - p0 writes word 0xDEADBEEF to 0x10 → `dram_we_o`=1 one cycle after gnt.
  - p0 then reads 0x10 → `p0_rvalid_o` at N+2 with `p0_rd_o`=0xDEADBEEF.
- **Contention (RR):**
  - Both ports issue 4 continuous reads to 0x0/0x4 → grants alternate 0,1,0,1 (`RR_INIT`=1).
  - 8 rvalid pulses, each on the correct port with correct data.
- **Fixed priority (macro off):** same stimulus → p1 is granted only after p0 drops req.
- **Read-after-write:** p1 writes byte 0x5A to 0x21, and next cycle p0 reads signed byte 0x21 → p0 gets 0x0000005A. A signed byte read of 0xA5 returns 0xFFFFFFA5.
- **Reset mid-write:** grant a p0 write to 0x30, then assert `rst_i` in the stage-B cycle → memory at 0x30 unchanged and no rvalid.
